// File: rtl/dram_burst_reader.sv
// DRAM read engine: splits a kick request into page-safe read bursts and streams the returned words.
// Optional build macro READ_TIMEOUT_EN adds an S_DATA watchdog that aborts and raises err.
module dram_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int PAGE_BYTES = 4096,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick,
  output logic                  busy,
  input  logic [31:0]           read_num,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           buf_dout,
  output logic                  buf_we,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [7:0]            mem_cmd_len,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  err
);

  // state  | meaning
  // S_IDLE | waiting for kick
  // S_CMD  | presenting one burst command until the controller accepts it
  // S_DATA | collecting the beats of the outstanding burst
  // S_DONE | one-cycle tail that drops busy
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  localparam int PAGE_BITS = $clog2(PAGE_BYTES);

  if (BURST_LEN < 1 || BURST_LEN > 256 || PAGE_BYTES < 4 * BURST_LEN || TIMEOUT < 1 ||
      ADDR_WIDTH <= PAGE_BITS) begin : g_bad_params
    $error("dram_burst_reader: illegal parameter combination");
  end

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           remaining;
  logic [8:0]            beats_r;
  logic [8:0]            beat_cnt;
  logic [31:0]           page_words;
  logic [8:0]            lim;
  logic [8:0]            beats;

  // Burst size is the smallest of what is left, the burst cap and the words up to the page end.
  always_comb begin
    page_words = (32'(PAGE_BYTES) - 32'(cur_addr[PAGE_BITS-1:0])) >> 2;
    lim        = (page_words < 32'(BURST_LEN)) ? 9'(page_words) : 9'(BURST_LEN);
    beats      = (remaining < 32'(lim)) ? 9'(remaining) : lim;
  end

`ifdef READ_TIMEOUT_EN
  localparam logic [31:0] WDOG_LOAD = 32'(TIMEOUT - 1);
  logic [31:0] wdog;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      buf_we        <= 1'b0;
      buf_dout      <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      beats_r       <= '0;
      beat_cnt      <= '0;
`ifdef READ_TIMEOUT_EN
      wdog          <= '0;
      err           <= 1'b0;
`endif
    end else begin
      buf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (kick) begin
            cur_addr  <= read_addr & ~ADDR_WIDTH'(3);
            remaining <= read_num;
            busy      <= 1'b1;
`ifdef READ_TIMEOUT_EN
            err       <= 1'b0;
`endif
            state     <= (read_num == 32'd0) ? S_DONE : S_CMD;
          end
        end
        S_CMD: begin
          // First cycle loads the command registers; they then hold until the handshake.
          if (!mem_cmd_valid) begin
            mem_cmd_valid <= 1'b1;
            mem_cmd_addr  <= cur_addr;
            mem_cmd_len   <= 8'(beats - 9'd1);
            beats_r       <= beats;
          end else if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            beat_cnt      <= '0;
`ifdef READ_TIMEOUT_EN
            wdog          <= WDOG_LOAD;
`endif
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem_rd_valid) begin
            buf_dout <= mem_rd_data;
            buf_we   <= 1'b1;
`ifdef READ_TIMEOUT_EN
            wdog     <= WDOG_LOAD;
`endif
            if (beat_cnt == beats_r - 9'd1) begin
              remaining <= remaining - 32'(beats_r);
              cur_addr  <= cur_addr + ADDR_WIDTH'({beats_r, 2'b00});
              state     <= (remaining == 32'(beats_r)) ? S_DONE : S_CMD;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
`ifdef READ_TIMEOUT_EN
          else if (wdog == 32'd0) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            wdog <= wdog - 32'd1;
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_reader.sv
// Scoreboard bench for dram_burst_reader: directed requests, a simple memory controller model,
// and a monitor that checks every command handshake and every buf_we strobe against queued expectations.
module tb_dram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kick = 1'b0;
  logic        busy;
  logic [31:0] read_num = '0;
  logic [31:0] read_addr = '0;
  logic [31:0] buf_dout;
  logic        buf_we;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b1;
  logic [31:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_len;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        err;

  always #5 clk = ~clk;

  dram_burst_reader #(.ADDR_WIDTH(32), .BURST_LEN(16), .PAGE_BYTES(4096), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .kick(kick), .busy(busy), .read_num(read_num), .read_addr(read_addr),
    .buf_dout(buf_dout), .buf_we(buf_we), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t        cmdq[$];
  logic [31:0] dataq[$];
  int          checks = 0;
  int          errors = 0;
  int          we_seen = 0;
  bit          end_chk = 1'b1;
  int          beat_cap = 1000;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [7:0] l);
    cmd_t c;
    c.addr = a;
    c.len  = l;
    cmdq.push_back(c);
  endtask

  task automatic push_data(input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) dataq.push_back(word_at(a + 32'(4 * k)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] n, input logic [31:0] a);
    kick      = 1'b1;
    read_num  = n;
    read_addr = a;
    tick();
    kick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 2000) begin
      tick();
      c++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_cmdq_empty"}, 64'(cmdq.size()), 64'd0);
    check({name, "_dataq_empty"}, 64'(dataq.size()), 64'd0);
  endtask

  // Memory controller model: accepts a command, then returns len+1 beats on consecutive cycles.
  int          m_left = 0;
  int          m_sent = 0;
  logic [31:0] m_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (m_left > 0) begin
        if (m_sent < beat_cap) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = word_at(m_addr);
        end else begin
          mem_rd_valid = 1'b0;
        end
        m_addr = m_addr + 32'd4;
        m_sent++;
        m_left--;
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
      end
      if (m_left == 0 && mem_cmd_valid && mem_cmd_ready) begin
        m_left = int'(mem_cmd_len) + 1;
        m_addr = mem_cmd_addr;
        m_sent = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a command handshake or a data strobe.
  bit          prev_v = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_a = '0;
  logic [7:0]  prev_l = '0;
  bit          busy_pend = 1'b0;
  initial begin
    cmd_t c;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (busy_pend) begin
        check("busy_fall_after_last_we", 64'(busy), 64'd0);
        busy_pend = 1'b0;
      end
      if (mem_cmd_valid && prev_v && !prev_hs) begin
        check("cmd_addr_stable", 64'(mem_cmd_addr), 64'(prev_a));
        check("cmd_len_stable", 64'(mem_cmd_len), 64'(prev_l));
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (cmdq.size() == 0) begin
          check("unexpected_cmd", 64'(mem_cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          c = cmdq.pop_front();
          check("cmd_addr", 64'(mem_cmd_addr), 64'(c.addr));
          check("cmd_len", 64'(mem_cmd_len), 64'(c.len));
        end
      end
      prev_v  = mem_cmd_valid;
      prev_hs = mem_cmd_valid && mem_cmd_ready;
      prev_a  = mem_cmd_addr;
      prev_l  = mem_cmd_len;
      if (buf_we) begin
        we_seen++;
        if (dataq.size() == 0) begin
          check("unexpected_we", 64'(buf_dout), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          d = dataq.pop_front();
          check("buf_dout", 64'(buf_dout), 64'(d));
          if (dataq.size() == 0 && end_chk) begin
            check("busy_at_last_we", 64'(busy), 64'd1);
            busy_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_buf_we", 64'(buf_we), 64'd0);
    check("rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_buf_dout", 64'(buf_dout), 64'd0);
    check("rst_cmd_addr", 64'(mem_cmd_addr), 64'd0);
    check("rst_cmd_len", 64'(mem_cmd_len), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // 64 words from a page start: four full bursts
    push_cmd(32'h1000, 8'd15);
    push_cmd(32'h1040, 8'd15);
    push_cmd(32'h1080, 8'd15);
    push_cmd(32'h10C0, 8'd15);
    push_data(32'h1000, 64);
    start(32'd64, 32'h1000);
    wait_idle("t1");
    tick();

    // 20 words straddling a page boundary
    push_cmd(32'h0FF8, 8'd1);
    push_cmd(32'h1000, 8'd15);
    push_cmd(32'h1040, 8'd1);
    push_data(32'h0FF8, 20);
    start(32'd20, 32'h0FF8);
    wait_idle("t2");
    tick();

    // zero-length request
    start(32'd0, 32'h1234);
    check("t3_busy_high", 64'(busy), 64'd1);
    tick();
    check("t3_busy_low", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t3_cmdq_empty", 64'(cmdq.size()), 64'd0);

    // controller stall with a second kick that must be ignored
    mem_cmd_ready = 1'b0;
    push_cmd(32'h2000, 8'd15);
    push_data(32'h2000, 16);
    start(32'd16, 32'h2000);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) kick = 1'b1;
      if (i == 4) read_num = 32'd3;
      if (i == 4) read_addr = 32'h7000;
      if (i == 5) kick = 1'b0;
      tick();
      check("t4_busy_stall", 64'(busy), 64'd1);
    end
    check("t4_cmd_valid_stall", 64'(mem_cmd_valid), 64'd1);
    mem_cmd_ready = 1'b1;
    wait_idle("t4");
    tick();

    // reset in the middle of a burst
    base = we_seen;
    push_cmd(32'h3000, 8'd15);
    push_data(32'h3000, 16);
    start(32'd16, 32'h3000);
    c = 0;
    while (we_seen < base + 5 && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("t5_five_beats", 64'(we_seen - base), 64'd5);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_buf_we", 64'(buf_we), 64'd0);
    check("t5_rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
    check("t5_rst_buf_dout", 64'(buf_dout), 64'd0);
    check("t5_rst_cmd_addr", 64'(mem_cmd_addr), 64'd0);
    check("t5_rst_cmd_len", 64'(mem_cmd_len), 64'd0);
    dataq.delete();
    repeat (3) tick();
    rst = 1'b1;
    base = we_seen;
    repeat (30) tick();
    check("t5_no_we_after_rst", 64'(we_seen - base), 64'd0);
    push_cmd(32'h4004, 8'd3);
    push_data(32'h4004, 4);
    start(32'd4, 32'h4006);
    wait_idle("t5_restart");
    tick();

`ifdef READ_TIMEOUT_EN
    // controller stops after 3 of 16 beats: watchdog abort
    end_chk  = 1'b0;
    beat_cap = 3;
    base     = we_seen;
    push_cmd(32'h5000, 8'd15);
    push_data(32'h5000, 3);
    start(32'd16, 32'h5000);
    c = 0;
    while (we_seen < base + 3 && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("t6_three_beats", 64'(we_seen - base), 64'd3);
    c = 0;
    while (!err && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("t6_idle_cycles_to_err", 64'(c), 64'd8);
    @(negedge clk);
    #1;
    check("t6_busy_after_abort", 64'(busy), 64'd0);
    check("t6_err_sticky", 64'(err), 64'd1);
    repeat (20) tick();
    check("t6_err_still_set", 64'(err), 64'd1);
    beat_cap = 1000;
    end_chk  = 1'b1;
    check("t6_dataq_empty", 64'(dataq.size()), 64'd0);
    check("t6_cmdq_empty", 64'(cmdq.size()), 64'd0);
    start(32'd0, 32'h6000);
    check("t6_err_cleared", 64'(err), 64'd0);
    wait_idle("t6_clear");
`else
    check("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_burst_reader.md
Name: dram_burst_reader

Overview:
- Single-clock DRAM read engine that serves the kick/busy/read_num/read_addr request interface of the UDP streaming sender.
- Splits each request into bounded memory read bursts. A burst never crosses a page boundary.
- Returns each word as buf_dout/buf_we with fixed one-cycle latency.
- Sits between the sender's frame FIFO loader and the memory controller's read command/data port.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- BURST_LEN, 16, maximum beats (32-bit words) per memory command; power of two, 1..256.
- PAGE_BYTES, 4096, bursts must not cross a multiple of this; power of two, at least 4*BURST_LEN.
- TIMEOUT, 1024, idle cycles allowed in S_DATA before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- kick  in  1  start pulse, sampled only in S_IDLE.
- busy  out  1  request in progress.
- read_num  in  32  words to read; sampled with kick.
- read_addr  in  ADDR_WIDTH  byte address of first word; word aligned, bits [1:0] ignored; sampled with kick.
- buf_dout  out  32  returned data word.
- buf_we  out  1  buf_dout valid strobe.
- mem_cmd_valid  out  1  read command valid.
- mem_cmd_ready  in  1  controller accepts command.
- mem_cmd_addr  out  ADDR_WIDTH  burst start byte address.
- mem_cmd_len  out  8  beats minus one.
- mem_rd_valid  in  1  read data beat valid; no backpressure.
- mem_rd_data  in  32  read data beat.
- err  out  1  timeout abort flag.

Behaviour:
- Reset (rst low, asynchronous): state S_IDLE; busy, buf_we, mem_cmd_valid, err = 0; buf_dout, mem_cmd_addr, mem_cmd_len = 0; all counters cleared. Reset mid-burst drops mem_cmd_valid immediately. Beats still in flight after reset release are ignored.
- States: S_IDLE, S_CMD, S_DATA, S_DONE.
- S_IDLE:
  - On kick, latch cur_addr = {read_addr[ADDR_WIDTH-1:2],2'b00} and remaining = read_num.
  - busy rises the next cycle. err clears on kick.
  - If read_num == 0, go to S_DONE (busy high exactly 1 cycle, no command issued). Otherwise go to S_CMD.
  - kick in any other state is ignored.
- S_CMD:
  - beats = min(remaining, BURST_LEN, (PAGE_BYTES - cur_addr mod PAGE_BYTES)/4).
  - Hold mem_cmd_valid=1, mem_cmd_addr=cur_addr, mem_cmd_len=beats-1, stable until mem_cmd_ready.
  - On handshake: deassert mem_cmd_valid next cycle, clear beat_cnt, go to S_DATA.
- S_DATA:
  - Each mem_rd_valid: buf_dout <= mem_rd_data and buf_we <= 1 on the next cycle. buf_we is a one-cycle strobe per beat.
  - On the beat where beat_cnt == beats-1: remaining -= beats; cur_addr += beats*4, wrapping modulo 2^ADDR_WIDTH.
  - Then go to S_DONE if the new remaining == 0, else to S_CMD. Only one command is outstanding at a time.
- S_DONE: busy=0 on entry cycle's output, return to S_IDLE. busy falls exactly one cycle after the last buf_we.
- mem_rd_valid outside S_DATA is dropped (no buf_we).
- Arithmetic:
  - remaining is 32-bit unsigned. read_num up to 2^32-1 is legal.
  - beats computation is 9-bit.
  - mem_cmd_len is the truncated 8-bit value.

Optional Feature:
- READ_TIMEOUT_EN defined:
  - A 32-bit watchdog counts S_DATA cycles since the last mem_rd_valid or command handshake.
  - On reaching TIMEOUT, go to S_DONE and set err=1. err stays sticky until the next accepted kick or reset.
  - Beats that arrive later are dropped.
- READ_TIMEOUT_EN undefined: no watchdog logic; err tied to 0; S_DATA waits indefinitely.

Test Plan:
- kick, read_num=64, read_addr=0x0000_1000, ready always 1, data one cycle after command → 4 commands at 0x1000/0x1040/0x1080/0x10C0, len=15 each; 64 buf_we strobes, data in order; busy low 1 cycle after the 64th strobe.
- read_num=20, read_addr=0x0000_0FF8 → commands (0x0FF8,len 1), (0x1000,len 15), (0x1040,len 1); 20 strobes total.
- read_num=0 → busy high exactly 1 cycle; no mem_cmd_valid; no buf_we.
- mem_cmd_ready held low 10 cycles with kick re-pulsed meanwhile → addr/len stable throughout; second kick ignored; request completes normally.
- rst asserted mid S_DATA after 5 of 16 beats → all outputs 0 asynchronously; remaining beats after release produce no buf_we; a new kick starts cleanly.
- READ_TIMEOUT_EN, TIMEOUT=8, controller returns 3 of 16 beats then stops → after 8 idle cycles: err=1, busy=0; next kick clears err.
